// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Constants and helpers shared by the FIFO family (sync_fifo_prog and the
//   dual-clock FIFOs that follow it).
//   Contents:
//     FIFO_DSIZE_DEF / FIFO_ASIZE_DEF : default data width / address width
//     RD_MODE_STD / RD_MODE_FWFT      : values for the FWFT read-mode parameter
//     fifo_clog2()                    : ceil(log2(n)) usable in constant context
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DSIZE_DEF = 8;
    localparam int FIFO_ASIZE_DEF = 4;

    localparam int RD_MODE_STD  = 0;
    localparam int RD_MODE_FWFT = 1;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int fifo_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
//   Simple dual-port storage for the FIFOs: one write port, one read port,
//   both synchronous to clk. The read data register resets to zero so the
//   FIFO's rdata has a defined value after reset; the array itself is never
//   cleared.
//   Ports:
//     clk, rst_n      : clock, synchronous active-low reset (read register only)
//     we, waddr, wdata: write port
//     re, raddr       : read enable / address, data appears on rdata next cycle
//     rdata           : registered read data (holds when re is low)
// -----------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE_DEF,
    parameter int DEPTH = 16,
    localparam int AW   = fifo_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [DSIZE-1:0] rdata
);

    (* ram_style = "auto" *) logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write on an address collision; the FWFT wrapper bypasses
    // the single case where that matters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//   Single-clock FIFO with occupancy count, programmable almost-full /
//   almost-empty thresholds, sticky overflow/underflow flags and a choice of
//   standard (registered, latency 1) or first-word-fall-through read.
//   Ports:
//     clk, rst_n        : clock, synchronous active-low reset
//     winc, wdata       : write request / data (ignored while wfull)
//     wfull             : count == DEPTH
//     walmost_full      : count >= AF_LEVEL
//     rinc, rdata       : read request / data (ignored while rempty)
//     rempty            : no readable word
//     ralmost_empty     : count <= AE_LEVEL
//     count             : words held, 0..DEPTH
//     overflow/underflow: sticky error flags, cleared by clr_err (set wins)
// -----------------------------------------------------------------------------
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DSIZE    = FIFO_DSIZE_DEF,
    parameter int ASIZE    = FIFO_ASIZE_DEF,
    parameter int FWFT     = RD_MODE_STD,
    parameter int AF_LEVEL = (1 << ASIZE) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int             DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] AF_C    = (ASIZE + 1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_C    = (ASIZE + 1)'(AE_LEVEL);
    localparam logic [ASIZE:0] ONE_C   = (ASIZE + 1)'(1);

    generate
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
            $error("sync_fifo_prog: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, DEPTH);
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
            $error("sync_fifo_prog: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
        end
        if (FWFT != RD_MODE_STD && FWFT != RD_MODE_FWFT) begin : g_bad_fwft
            $error("sync_fifo_prog: FWFT=%0d must be 0 or 1", FWFT);
        end
    endgenerate

    logic [ASIZE-1:0] wptr_reg;
    logic [ASIZE-1:0] rptr_reg;
    logic [ASIZE-1:0] rptr_next;
    logic [ASIZE:0]   count_reg;
    logic [ASIZE:0]   count_next;
    logic             wfull_reg;
    logic             walmost_full_reg;
    logic             rempty_reg;
    logic             ralmost_empty_reg;
    logic             overflow_reg;
    logic             underflow_reg;

    logic             wr_ok;
    logic             rd_ok;
    logic             ram_re;
    logic [ASIZE-1:0] ram_raddr;
    logic [DSIZE-1:0] ram_rdata;

    // A full FIFO refuses writes even when a read frees a slot on the same edge.
    assign wr_ok     = winc & ~wfull_reg;
    assign rd_ok     = rinc & ~rempty_reg;
    assign rptr_next = rptr_reg + ASIZE'(rd_ok);

    always_comb begin
        count_next = count_reg;
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + ONE_C;
        end else if (!wr_ok && rd_ok) begin
            count_next = count_reg - ONE_C;
        end
    end

    // Flags are derived from the next count so they track each accepted op
    // on the very edge it happens.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_reg          <= '0;
            rptr_reg          <= '0;
            count_reg         <= '0;
            wfull_reg         <= 1'b0;
            walmost_full_reg  <= 1'b0;
            rempty_reg        <= 1'b1;
            ralmost_empty_reg <= 1'b1;
        end else begin
            if (wr_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            rptr_reg          <= rptr_next;
            count_reg         <= count_next;
            wfull_reg         <= (count_next == DEPTH_C);
            walmost_full_reg  <= (count_next >= AF_C);
            rempty_reg        <= (count_next == '0);
            ralmost_empty_reg <= (count_next <= AE_C);
        end
    end

    // Sticky error flags: a new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (winc && wfull_reg) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
            if (rinc && rempty_reg) begin
                underflow_reg <= 1'b1;
            end else if (clr_err) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok & rst_n),
        .waddr (wptr_reg),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT != RD_MODE_STD) begin : g_fwft
            // The RAM output register doubles as the head-of-queue register:
            // every cycle it re-reads the address the head will occupy after
            // this edge. The only time that word is being written on the same
            // edge (empty FIFO, or last word popped while a new one arrives)
            // the RAM returns stale data, so wdata is captured alongside and
            // selected instead. Both registers hold while the FIFO goes empty
            // so an underflowing read leaves rdata untouched.
            logic             byp_hit_reg;
            logic [DSIZE-1:0] byp_data_reg;

            assign ram_raddr = rptr_next;
            assign ram_re    = (count_next != '0);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    byp_hit_reg  <= 1'b0;
                    byp_data_reg <= '0;
                end else if (ram_re) begin
                    byp_hit_reg  <= wr_ok && (wptr_reg == rptr_next);
                    byp_data_reg <= wdata;
                end
            end

            assign rdata = byp_hit_reg ? byp_data_reg : ram_rdata;
        end else begin : g_std
            assign ram_raddr = rptr_reg;
            assign ram_re    = rd_ok;
            assign rdata     = ram_rdata;
        end
    endgenerate

    assign wfull         = wfull_reg;
    assign walmost_full  = walmost_full_reg;
    assign rempty        = rempty_reg;
    assign ralmost_empty = ralmost_empty_reg;
    assign count         = count_reg;
    assign overflow      = overflow_reg;
    assign underflow     = underflow_reg;

endmodule
